// File: rtl/uart_pkg.sv
// Shared UART receiver definitions: payload width, FSM state encoding and timer sizing.
package uart_pkg;

  localparam int unsigned DATA_BITS = 8;
  localparam int unsigned BIT_CNT_W = $clog2(DATA_BITS + 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_HIGH
  } rx_state_t;

  function automatic int unsigned timer_width(input int unsigned clks_per_bit);
    return $clog2(clks_per_bit);
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the asynchronous serial line plus falling-edge detect.
// All flops reset to the idle-high level so reset release cannot look like a start edge.
module uart_rx_sync (
  input  logic clk,
  input  logic rstn,
  input  logic serial_in,
  output logic rx_s,
  output logic fall_c
);

  logic meta;
  logic rx_d;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      meta <= 1'b1;
      rx_s <= 1'b1;
      rx_d <= 1'b1;
    end else begin
      meta <= serial_in;
      rx_s <= meta;
      rx_d <= rx_s;
    end
  end

  assign fall_c = rx_d & ~rx_s;

endmodule

// File: rtl/uart_receiver.sv
// 8N1 UART receiver, LSB first, with valid/read host handshake and overrun/framing flags.
// Optional UART_RX_MAJORITY_EN: 2-of-3 vote around each mid-bit, decision one clk later.
module uart_receiver
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 serial_in,
  input  logic                 data_read,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 data_valid,
  output logic                 framing_err,
  output logic                 overrun
);

  localparam int unsigned TIMER_W = timer_width(CLKS_PER_BIT);
  localparam int unsigned BIT_END = CLKS_PER_BIT - 1;
`ifdef UART_RX_MAJORITY_EN
  localparam int unsigned START_MID = CLKS_PER_BIT / 2;
`else
  localparam int unsigned START_MID = CLKS_PER_BIT / 2 - 1;
`endif

  rx_state_t              state;
  logic [TIMER_W-1:0]     timer;
  logic [BIT_CNT_W-1:0]   bit_cnt;
  logic [DATA_BITS-1:0]   shreg;
  logic                   rx_s;
  logic                   fall_c;
  logic                   tick_c;
  logic                   bit_val_c;

  uart_rx_sync u_sync (
    .clk       (clk),
    .rstn      (rstn),
    .serial_in (serial_in),
    .rx_s      (rx_s),
    .fall_c    (fall_c)
  );

`ifdef UART_RX_MAJORITY_EN
  logic rx_h1;
  logic rx_h2;

  // Two older samples of rx_s; vote spans mid-1, mid, mid+1 at the decision point.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rx_h1 <= 1'b1;
      rx_h2 <= 1'b1;
    end else begin
      rx_h1 <= rx_s;
      rx_h2 <= rx_h1;
    end
  end

  assign bit_val_c = (rx_h2 & rx_h1) | (rx_h2 & rx_s) | (rx_h1 & rx_s);
`else
  assign bit_val_c = rx_s;
`endif

  // Decision point: mid start bit in START, then one full bit period apart.
  always_comb begin
    tick_c = 1'b0;
    case (state)
      START:      tick_c = (timer == TIMER_W'(START_MID));
      DATA, STOP: tick_c = (timer == TIMER_W'(BIT_END));
      default:    tick_c = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state       <= IDLE;
      timer       <= '0;
      bit_cnt     <= '0;
      shreg       <= '0;
      data_out    <= '0;
      data_valid  <= 1'b0;
      framing_err <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      framing_err <= 1'b0;
      timer       <= tick_c ? '0 : timer + TIMER_W'(1);

      if (data_read && data_valid) begin
        data_valid <= 1'b0;
        overrun    <= 1'b0;
      end

      case (state)
        IDLE: begin
          timer <= '0;
          if (fall_c) state <= START;
        end
        START: begin
          if (tick_c) begin
            if (bit_val_c) begin
              state <= IDLE;
            end else begin
              bit_cnt <= '0;
              state   <= DATA;
            end
          end
        end
        DATA: begin
          if (tick_c) begin
            shreg   <= {bit_val_c, shreg[DATA_BITS-1:1]};
            bit_cnt <= bit_cnt + BIT_CNT_W'(1);
            if (bit_cnt == BIT_CNT_W'(DATA_BITS - 1)) state <= STOP;
          end
        end
        STOP: begin
          if (tick_c) begin
            if (bit_val_c) begin
              state <= IDLE;
              // A same-cycle read frees the holding register for the new byte.
              if (!data_valid || data_read) begin
                data_out   <= shreg;
                data_valid <= 1'b1;
              end else begin
                overrun <= 1'b1;
              end
            end else begin
              framing_err <= 1'b1;
              state       <= WAIT_HIGH;
            end
          end
        end
        WAIT_HIGH: begin
          timer <= '0;
          if (rx_s) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
